// File: rtl/ad_capture_pkg.sv
// Shared constants for the AD9238 capture block: FSM state encoding,
// trigger-mode codes and the default sample width.
package ad_capture_pkg;

  localparam int DATA_W_DEF = 12;

  // Capture FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Trigger modes; code 3 is reserved and behaves like TRIG_IMM
  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;

endpackage

// File: rtl/ad_trig_detect.sv
// Threshold trigger: compares the previous kept sample (s2) with the current
// one (s1) as unsigned offset-binary values. Edge modes need a valid
// predecessor, so they are suppressed on the first kept sample after arm.
module ad_trig_detect
  import ad_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] s1_i,
  input  logic [DATA_W-1:0] s2_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic [1:0]        mode_i,
  input  logic              sample_en_i,
  input  logic              first_i,
  output logic              trig_o
);

  // Evaluate the trigger condition only on kept samples
  always_comb begin
    trig_o = 1'b0;
    if (sample_en_i) begin
      case (mode_i)
        TRIG_RISE: trig_o = !first_i && (s2_i < level_i) && (s1_i >= level_i);
        TRIG_FALL: trig_o = !first_i && (s2_i > level_i) && (s1_i <= level_i);
        default:   trig_o = first_i;
      endcase
    end
  end

endmodule

// File: rtl/ad9238_capture.sv
// AD9238 capture front end: registers ADC samples, decimates, waits for a
// threshold trigger and then streams a fixed DEPTH-sample record into an
// external simple-dual-port RAM through registered write outputs.
module ad9238_capture
  import ad_capture_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               adc_clk,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_otr,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic [DECIM_W-1:0] decim,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic               ovr
);

  // Address of the write just before the last one; reaching it in CAPTURE
  // means the next kept sample completes the record.
  localparam logic [ADDR_W-1:0] ADDR_PENULT = {{(ADDR_W-1){1'b1}}, 1'b0};

  // ADC samples on the falling capture edge so data is stable at our rising edge
  assign adc_clk = ~clk;

  logic [DATA_W-1:0]  s1_data_q, s2_data_q;
  logic               s1_otr_q;
  logic [DECIM_W-1:0] cnt_q, decim_l_q;
  logic [1:0]         mode_l_q;
  logic [DATA_W-1:0]  level_l_q;
  logic [1:0]         state_q, state_d;
  logic               first_q, first_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic               sample_en, arm_ok, trig;

  // arm is honoured only from IDLE or DONE, and abort always wins
  assign arm_ok    = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign sample_en = (cnt_q == '0);

  // Input stage: s1 follows the pins every cycle, s2 holds the previous kept sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q <= '0;
      s1_otr_q  <= 1'b0;
      s2_data_q <= '0;
    end else begin
      s1_data_q <= adc_data;
      s1_otr_q  <= adc_otr;
      if (sample_en) s2_data_q <= s1_data_q;
    end
  end

  // Decimation counter and trigger configuration, both latched on arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      decim_l_q <= '0;
      mode_l_q  <= TRIG_IMM;
      level_l_q <= '0;
    end else if (arm_ok) begin
      cnt_q     <= '0;
      decim_l_q <= decim;
      mode_l_q  <= trig_mode;
      level_l_q <= trig_level;
    end else if (cnt_q == decim_l_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  ad_trig_detect #(
    .DATA_W(DATA_W)
  ) u_trig (
    .s1_i       (s1_data_q),
    .s2_i       (s2_data_q),
    .level_i    (level_l_q),
    .mode_i     (mode_l_q),
    .sample_en_i(sample_en),
    .first_i    (first_q),
    .trig_o     (trig)
  );

  // Capture FSM next-state and write-port logic
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    if (abort) begin
      state_d   = ST_IDLE;
      wr_addr_d = '0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d   = ST_ARMED;
            first_d   = 1'b1;
            wr_addr_d = '0;
            done_d    = 1'b0;
            ovr_d     = 1'b0;
          end
        end
        ST_ARMED: begin
          if (sample_en) begin
            first_d = 1'b0;
            if (trig) begin
              state_d   = ST_CAPTURE;
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = s1_data_q;
              if (s1_otr_q) ovr_d = 1'b1;
            end
          end
        end
        default: begin
          if (sample_en) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
            wr_data_d = s1_data_q;
            if (s1_otr_q) ovr_d = 1'b1;
            if (wr_addr_q == ADDR_PENULT) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Capture FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      first_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign ovr     = ovr_q;
  assign busy    = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_ad9238_capture.sv
// Directed bench for ad9238_capture: ramps are driven on the pins, every RAM
// write is logged, and each scenario task compares the log and flags against
// hand-derived expectations.
module tb_ad9238_capture;
  import ad_capture_pkg::*;

  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 10;
  localparam int DECIM_W = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               adc_clk;
  logic [DATA_W-1:0]  adc_data = '0;
  logic               adc_otr = 1'b0;
  logic               arm = 1'b0;
  logic               abort = 1'b0;
  logic [1:0]         trig_mode = TRIG_IMM;
  logic [DATA_W-1:0]  trig_level = '0;
  logic [DECIM_W-1:0] decim = '0;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               busy, done, ovr;

  ad9238_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DECIM_W(DECIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .adc_clk(adc_clk), .adc_data(adc_data), .adc_otr(adc_otr),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level), .decim(decim),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Write log filled by capture_loop
  int   nwr;
  bit   done_seen;
  logic last_done, last_busy, first_busy;
  int   addr_log [DEPTH];
  int   data_log [DEPTH];
  int   cyc_log  [DEPTH];
  logic ovr_log  [DEPTH];

  // Drive data = base + step*n from the arm cycle (n=0) and log every write.
  // Negedge n shows the result of the posedge following negedge n-1.
  task automatic capture_loop(input int base, input int step, input int otr_cyc,
                              input int abort_cyc, input int stop_cyc, input int max_cyc);
    nwr = 0; done_seen = 0; last_done = 0; last_busy = 1; first_busy = 0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (n > 0) begin
        if (wr_en) begin
          if (nwr < DEPTH) begin
            addr_log[nwr] = int'(wr_addr);
            data_log[nwr] = int'(wr_data);
            cyc_log[nwr]  = n;
            ovr_log[nwr]  = ovr;
          end
          if (nwr == 0) first_busy = busy;
          if (int'(wr_addr) == DEPTH - 1) begin
            last_done = done;
            last_busy = busy;
          end
          nwr++;
        end
        if (done) begin
          done_seen = 1;
          break;
        end
      end
      if (n == stop_cyc) break;
      adc_data = DATA_W'(base + step * n);
      adc_otr  = (n == otr_cyc);
      arm      = (n == 0);
      abort    = (n == abort_cyc);
    end
    arm = 0; abort = 0; adc_otr = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++; if ({wr_en, busy, done, ovr} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {wr_en, busy, done, ovr}); else pass_cnt++;
    total_cnt++; if (wr_addr !== '0) $display("FAIL reset_addr: got %0h expected 0", wr_addr); else pass_cnt++;
    total_cnt++; if (wr_data !== '0) $display("FAIL reset_data: got %0h expected 0", wr_data); else pass_cnt++;
    total_cnt++; if (adc_clk !== 1'b1) $display("FAIL adc_clk_inv: got %b expected 1 while clk low", adc_clk); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_immediate(input string name);
    int err = 0, bad = -1;
    trig_mode = TRIG_IMM; decim = '0;
    capture_loop(0, 1, -1, -1, -1, 1100);
    total_cnt++; if (done_seen !== 1'b1) $display("FAIL %s_done_seen: got %0d expected 1 within budget", name, done_seen); else pass_cnt++;
    total_cnt++; if (nwr !== DEPTH) $display("FAIL %s_count: got %0d writes expected %0d", name, nwr, DEPTH); else pass_cnt++;
    for (int i = 0; i < DEPTH && i < nwr; i++)
      if (addr_log[i] != i || data_log[i] != i || cyc_log[i] != i + 2) begin
        err++; if (bad < 0) bad = i;
      end
    total_cnt++; if (err !== 0) $display("FAIL %s_seq: %0d bad writes, first idx %0d addr %0d data %0h cyc %0d expected addr=data=idx cyc=idx+2", name, err, bad, addr_log[bad < 0 ? 0 : bad], data_log[bad < 0 ? 0 : bad], cyc_log[bad < 0 ? 0 : bad]); else pass_cnt++;
    total_cnt++; if (first_busy !== 1'b1) $display("FAIL %s_busy_first: got %b expected 1", name, first_busy); else pass_cnt++;
    total_cnt++; if ({last_done, last_busy} !== 2'b10) $display("FAIL %s_last_done_busy: got %b expected 10", name, {last_done, last_busy}); else pass_cnt++;
    total_cnt++; if (ovr !== 1'b0) $display("FAIL %s_ovr: got %b expected 0", name, ovr); else pass_cnt++;
  endtask

  task automatic test_rising();
    int err = 0;
    trig_mode = TRIG_RISE; trig_level = 12'h800; decim = '0;
    capture_loop(12'h7F0, 1, -1, -1, -1, 1200);
    total_cnt++; if (nwr !== DEPTH) $display("FAIL rise_count: got %0d expected %0d", nwr, DEPTH); else pass_cnt++;
    total_cnt++; if (data_log[0] !== 12'h800) $display("FAIL rise_first_data: got %0h expected 800", data_log[0]); else pass_cnt++;
    total_cnt++; if (cyc_log[0] !== 18) $display("FAIL rise_first_cyc: got %0d expected 18", cyc_log[0]); else pass_cnt++;
    for (int i = 0; i < DEPTH && i < nwr; i++)
      if (addr_log[i] != i || data_log[i] != 'h800 + i || cyc_log[i] != 18 + i) err++;
    total_cnt++; if (err !== 0) $display("FAIL rise_seq: got %0d bad writes expected 0", err); else pass_cnt++;
  endtask

  task automatic test_falling_decim();
    int err = 0;
    trig_mode = TRIG_FALL; trig_level = 12'h400; decim = 16'd3;
    capture_loop(12'h410, -1, -1, -1, -1, 4300);
    total_cnt++; if (nwr !== DEPTH) $display("FAIL fall_count: got %0d expected %0d", nwr, DEPTH); else pass_cnt++;
    total_cnt++; if (data_log[0] !== 12'h400) $display("FAIL fall_first_data: got %0h expected 400", data_log[0]); else pass_cnt++;
    total_cnt++; if (cyc_log[1] - cyc_log[0] !== 4) $display("FAIL fall_spacing: got %0d expected 4", cyc_log[1] - cyc_log[0]); else pass_cnt++;
    total_cnt++; if (data_log[1] !== 12'h3FC) $display("FAIL fall_second_data: got %0h expected 3fc", data_log[1]); else pass_cnt++;
    for (int i = 0; i < DEPTH && i < nwr; i++)
      if (addr_log[i] != i || data_log[i] != (('h400 - 4 * i) & 'hFFF) || cyc_log[i] != 18 + 4 * i) err++;
    total_cnt++; if (err !== 0) $display("FAIL fall_seq: got %0d bad writes expected 0", err); else pass_cnt++;
    decim = '0;
  endtask

  task automatic test_ovr();
    trig_mode = TRIG_IMM; decim = '0;
    capture_loop(0, 1, 300, -1, -1, 1100);
    total_cnt++; if ({ovr_log[299], ovr_log[300]} !== 2'b01) $display("FAIL ovr_set_point: got %b expected 01", {ovr_log[299], ovr_log[300]}); else pass_cnt++;
    total_cnt++; if ({done, ovr} !== 2'b11) $display("FAIL ovr_after_done: got %b expected 11", {done, ovr}); else pass_cnt++;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    total_cnt++; if ({ovr, done, busy} !== 3'b001) $display("FAIL ovr_rearm: got %b expected 001", {ovr, done, busy}); else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL ovr_abort_idle: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_abort();
    trig_mode = TRIG_IMM; decim = '0;
    capture_loop(0, 1, -1, 502, 503, 600);
    total_cnt++; if (nwr !== 501) $display("FAIL abort_count: got %0d expected 501", nwr); else pass_cnt++;
    total_cnt++; if ({wr_en, busy, done} !== 3'b000) $display("FAIL abort_flags: got %b expected 000", {wr_en, busy, done}); else pass_cnt++;
    total_cnt++; if (wr_addr !== '0) $display("FAIL abort_addr: got %0h expected 0", wr_addr); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if ({wr_en, busy} !== 2'b00) $display("FAIL abort_stays_idle: got %b expected 00", {wr_en, busy}); else pass_cnt++;
    test_immediate("after_abort");
  endtask

  task automatic test_async_reset_and_arm_abort();
    trig_mode = TRIG_IMM; decim = '0;
    capture_loop(12'h123, 1, 50, -1, 200, 300);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({wr_en, busy, done, ovr} !== 4'b0000) $display("FAIL async_rst_flags: got %b expected 0000", {wr_en, busy, done, ovr}); else pass_cnt++;
    total_cnt++; if ({wr_addr, wr_data} !== '0) $display("FAIL async_rst_addr_data: got %0h/%0h expected 0/0", wr_addr, wr_data); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL arm_abort_busy: got %b expected 0", busy); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if ({wr_en, busy, done} !== 3'b000) $display("FAIL arm_abort_idle: got %b expected 000", {wr_en, busy, done}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_immediate("imm");
    test_rising();
    test_falling_decim();
    test_ovr();
    test_abort();
    test_async_reset_and_arm_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ad9238_capture.md
Name: ad9238_capture

Overview:
- Receive-side counterpart of the dual-port DA ramp generator: captures 12-bit offset-binary samples from an AN9238-class ADC module.
- Provides optional decimation and a threshold trigger, then writes a fixed-length record into an external simple-dual-port RAM.
- Sits between the ADC pins and the capture RAM; a host or test-pattern loop reads the RAM once done is set.
- Intended bench use: loop the DA ramp output back into this block.

Parameters:
DATA_W, 12, ADC sample width (offset binary, 0 = most negative)
ADDR_W, 10, RAM address width; record length DEPTH = 2**ADDR_W
DECIM_W, 16, width of the decimation divider input

Ports:
clk  in  1  capture clock; also the ADC sample clock source
rst_n  in  1  asynchronous active-low reset
adc_clk  out  1  clock to ADC, = ~clk (combinational) so the ADC output settles mid-cycle
adc_data  in  DATA_W  ADC parallel data
adc_otr  in  1  ADC out-of-range flag, aligned with adc_data
arm  in  1  single-cycle pulse: start waiting for trigger
abort  in  1  single-cycle pulse: return to IDLE
trig_mode  in  2  0 = immediate, 1 = rising crossing, 2 = falling crossing, 3 = reserved (acts as 0)
trig_level  in  DATA_W  trigger threshold
decim  in  DECIM_W  keep one sample every decim+1 clocks (0 = every clock)
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  DATA_W  RAM write data
busy  out  1  high in ARMED or CAPTURE
done  out  1  record complete, held until next arm
ovr  out  1  sticky: at least one OTR sample stored in current record

Behaviour:
- Reset (async, rst_n=0): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, ovr=0; pipeline registers and decimation counter cleared.
- Input stage: adc_data/adc_otr registered into s1 every clk rising edge; s1 copied to s2 each cycle a sample is kept.
- Decimation: counter runs 0..decim_l, then wraps to 0; sample_en=1 when the counter is 0.
  - decim_l is decim latched on arm; the counter is cleared on arm.
  - decim changes outside arm have no effect.
- trig_mode and trig_level are latched on arm.
- Trigger evaluation happens only on sample_en, comparing s2 (previous kept sample) with s1 (current), unsigned:
  - rising: s2 < level and s1 >= level;
  - falling: s2 > level and s1 <= level;
  - immediate: true on the first sample_en after entering ARMED.
  - The first kept sample after arm has no valid predecessor, so edge modes do not fire on it.
- States:
  - IDLE: arm -> ARMED; clears done and ovr.
  - ARMED: trigger true -> CAPTURE. The triggering sample (s1) is written at address 0 in that same cycle.
  - CAPTURE: on each sample_en, wr_en=1, wr_data=s1, and wr_addr increments. After the write at DEPTH-1: state DONE, done=1.
  - DONE: arm -> ARMED (done and ovr cleared, wr_addr=0); otherwise hold.
- Latency: a sample at the pins before clk edge k lands in s1 at edge k and appears on wr_data with wr_en at edge k+1 (registered outputs).
- wr_en is high for exactly one cycle per stored sample; exactly DEPTH writes per record, addresses 0..DEPTH-1, no wrap.
- ovr: set when a stored sample has otr=1; cleared only by arm or reset.
- abort in any state -> IDLE next cycle; wr_en=0, busy=0, done=0, wr_addr=0. The partial record is abandoned.
- Simultaneous arm and abort: abort wins.
- arm while ARMED or CAPTURE: ignored.
- busy is combinational from the state register (ARMED or CAPTURE).
- Level exactly equal: rising requires the previous sample strictly below the level and the current sample >= level.

Decomposition:
- Package ad_capture_pkg: state encoding (IDLE, ARMED, CAPTURE, DONE), trig_mode constants TRIG_IMM/TRIG_RISE/TRIG_FALL, DATA_W default.
- One natural sub-module, ad_trig_detect: takes s1, s2, level, mode, sample_en and first-sample flag; outputs trig.
- Decimator and FSM stay in the top.

Test Plan:
- Immediate mode, decim=0, adc_data ramps 0,1,2,... from the arm cycle -> 1024 consecutive wr_en pulses, addr 0..1023, data strictly increasing by 1, done=1 after the last write, busy falls the same cycle.
- Rising mode, level=0x800, ramp 0x7F0 upward -> first write carries 0x800 at addr 0; no write occurs before it.
- Falling mode, level=0x400, descending ramp 0x410 downward, decim=3 -> wr_en every 4th cycle; addr 0 holds the first kept sample <= 0x400; consecutive stored values differ by 4.
- Pulse adc_otr for one cycle mid-record with decim=0 -> ovr=1 and stays 1 after done; the next arm clears it.
- abort at addr 500 -> next cycle IDLE, wr_en=0, wr_addr=0, done=0. A new arm gives a clean full record starting at addr 0.
- rst_n low mid-CAPTURE -> all outputs at reset values immediately (async); arm asserted together with abort -> stays IDLE.
